// File: rtl/sound_pkg.sv
// Shared types, constants and helpers for the 16-point inverse FFT.
package sound_pkg;

    localparam int SAMPLE_W = 16;
    localparam int N        = 16;
    localparam int LOG2N    = 4;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // W^-t = cos(2*pi*t/16) + j*sin(2*pi*t/16) in Q1.15; +1.0 clamps to 0x7FFF.
    localparam cplx_t INV_TWIDDLE [8] = '{
        '{re:  16'sd32767, im:  16'sd0},
        '{re:  16'sd30274, im:  16'sd12540},
        '{re:  16'sd23170, im:  16'sd23170},
        '{re:  16'sd12540, im:  16'sd30274},
        '{re:  16'sd0,     im:  16'sd32767},
        '{re: -16'sd12540, im:  16'sd30274},
        '{re: -16'sd23170, im:  16'sd23170},
        '{re: -16'sd30274, im:  16'sd12540}
    };

    function automatic logic [3:0] bitrev4(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly with per-stage 1/2 scaling and no saturation.
module ifft_butterfly
    import sound_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    input  cplx_t w,
    input  logic  bypass,
    output cplx_t top,
    output cplx_t bot
);

    logic signed [31:0] rr, ii, ri, ir;
    logic signed [31:0] sum_re, sum_im;
    logic signed [16:0] p_re, p_im;
    logic signed [17:0] top_re, top_im, bot_re, bot_im;
    logic               unused_bits;

    always_comb begin
        rr = b.re * w.re;
        ii = b.im * w.im;
        ri = b.re * w.im;
        ir = b.im * w.re;
        // The largest twiddle magnitude keeps both sums inside 32 bits.
        sum_re = rr - ii + 32'sd16384;
        sum_im = ri + ir + 32'sd16384;
        if (bypass) begin
            p_re = {b.re[15], b.re};
            p_im = {b.im[15], b.im};
        end else begin
            p_re = sum_re[31:15];
            p_im = sum_im[31:15];
        end
        top_re = {{2{a.re[15]}}, a.re} + {p_re[16], p_re};
        top_im = {{2{a.im[15]}}, a.im} + {p_im[16], p_im};
        bot_re = {{2{a.re[15]}}, a.re} - {p_re[16], p_re};
        bot_im = {{2{a.im[15]}}, a.im} - {p_im[16], p_im};
        // Bits [16:1] are the arithmetic halving truncated back to 16 bits.
        top = '{re: top_re[16:1], im: top_im[16:1]};
        bot = '{re: bot_re[16:1], im: bot_im[16:1]};
    end

    assign unused_bits = ^{sum_re[14:0], sum_im[14:0], top_re[17], top_re[0],
                           top_im[17], top_im[0], bot_re[17], bot_re[0],
                           bot_im[17], bot_im[0]};

endmodule

// File: rtl/sound_ifft16.sv
// 16-point in-place inverse FFT: bit-reversed load, 32 serial butterflies, natural-order drain.
module sound_ifft16
    import sound_pkg::*;
(
    input  logic                       Clock,
    input  logic                       Areset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] in_re,
    input  logic signed [SAMPLE_W-1:0] in_im,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SAMPLE_W-1:0] out_re,
    output logic signed [SAMPLE_W-1:0] out_im,
    output logic                       out_last,
    output logic                       busy,
    output state_t                     state_dbg
);

    // A transfer happens on an edge where valid and ready are both high;
    // valid never waits on ready, and data is held while valid && !ready.

    state_t     state;
    logic [3:0] load_cnt;
    logic [1:0] stage;
    logic [2:0] bfly;
    logic [3:0] out_cnt;
    cplx_t      mem [N];

    logic       load_fire;
    logic [3:0] bfly_ext, half, pos, top_idx, bot_idx;
    logic [2:0] tw_idx;
    cplx_t      bf_a, bf_b, bf_w, bf_top, bf_bot;

    always_comb begin
        bfly_ext = {1'b0, bfly};
        half     = 4'd1 << stage;
        pos      = bfly_ext & (half - 4'd1);
        top_idx  = ((bfly_ext >> stage) << ({1'b0, stage} + 3'd1)) + pos;
        bot_idx  = top_idx + half;
        tw_idx   = 3'(pos << (2'd3 - stage));
        bf_a     = mem[top_idx];
        bf_b     = mem[bot_idx];
        bf_w     = INV_TWIDDLE[tw_idx];
    end

    ifft_butterfly u_butterfly (
        .a      (bf_a),
        .b      (bf_b),
        .w      (bf_w),
        .bypass (tw_idx == 3'd0),
        .top    (bf_top),
        .bot    (bf_bot)
    );

    // Outputs decode straight from registered state, so reset takes effect on its edge.
    assign in_ready  = ((state == IDLE) || (state == LOAD)) && !Areset;
    assign load_fire = in_valid && in_ready;
    assign out_valid = (state == DRAIN);
    assign out_last  = (state == DRAIN) && (out_cnt == 4'd15);
    assign busy      = (state != IDLE);
    assign out_re    = mem[out_cnt].re;
    assign out_im    = mem[out_cnt].im;
    assign state_dbg = state;

    always_ff @(posedge Clock) begin
        if (Areset) begin
            state    <= IDLE;
            load_cnt <= '0;
            stage    <= '0;
            bfly     <= '0;
            out_cnt  <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (in_valid) begin
                        load_cnt <= load_cnt + 4'd1;
                        state    <= (load_cnt == 4'd15) ? COMPUTE : LOAD;
                    end
                end
                COMPUTE: begin
                    bfly <= bfly + 3'd1;
                    if (bfly == 3'd7) begin
                        stage <= stage + 2'd1;
                        if (stage == 2'd3) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        out_cnt <= out_cnt + 4'd1;
                        if (out_cnt == 4'd15) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory is not reset; a discarded frame is never drained because reset forces IDLE.
    always_ff @(posedge Clock) begin
        if (load_fire) begin
            mem[bitrev4(load_cnt)] <= '{re: in_re, im: in_im};
        end else if ((state == COMPUTE) && !Areset) begin
            mem[top_idx] <= bf_top;
            mem[bot_idx] <= bf_bot;
        end
    end

endmodule

// File: tb/tb_sound_ifft16.sv
// Self-checking bench for sound_ifft16 against an array-based fixed-point IFFT model.
module tb_sound_ifft16;
    import sound_pkg::*;

    localparam real PI = 3.14159265358979323846;

    logic               Clock = 1'b0;
    logic               Areset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_re = '0;
    logic signed [15:0] in_im = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_re, out_im;
    logic               out_last;
    logic               busy;
    state_t             state_dbg;

    sound_ifft16 dut (
        .Clock     (Clock),
        .Areset    (Areset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    always #5 Clock = ~Clock;

    int          checks = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    int          xr[16], xi[16], yr[16], yi[16];
    int          tw_re[8], tw_im[8];
    bit          bp_en = 1'b0;
    bit          started = 1'b0;
    time         last_pop_time = 0;
    time         last_accept_time = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sx(input longint v, input int bits);
        longint m;
        m = v << (64 - bits);
        return int'(m >>> (64 - bits));
    endfunction

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < 4; i++) if (((k >> i) & 1) != 0) r |= 1 << (3 - i);
        return r;
    endfunction

    function automatic int rnd(input real x);
        return $rtoi($floor(x + 0.5));
    endfunction

    // Iterative in-place DIT inverse FFT on plain integers, scaled by 1/2 per stage.
    task automatic run_model();
        int     ar[16], ai[16];
        int     half, pos, top, bot, t, pr, pi, nr, ni;
        longint sr, si;
        for (int k = 0; k < 16; k++) begin
            ar[brev(k)] = xr[k];
            ai[brev(k)] = xi[k];
        end
        for (int s = 0; s < 4; s++) begin
            half = 1 << s;
            for (int b = 0; b < 8; b++) begin
                pos = b % half;
                top = (b / half) * 2 * half + pos;
                bot = top + half;
                t   = pos * (8 / half);
                if (t == 0) begin
                    pr = ar[bot];
                    pi = ai[bot];
                end else begin
                    sr = longint'(ar[bot]) * tw_re[t] - longint'(ai[bot]) * tw_im[t] + 16384;
                    si = longint'(ar[bot]) * tw_im[t] + longint'(ai[bot]) * tw_re[t] + 16384;
                    pr = sx(sr >>> 15, 17);
                    pi = sx(si >>> 15, 17);
                end
                nr = ar[top];
                ni = ai[top];
                ar[top] = sx((nr + pr) >>> 1, 16);
                ai[top] = sx((ni + pi) >>> 1, 16);
                ar[bot] = sx((nr - pr) >>> 1, 16);
                ai[bot] = sx((ni - pi) >>> 1, 16);
            end
        end
        for (int n = 0; n < 16; n++) begin
            yr[n] = ar[n];
            yi[n] = ai[n];
        end
    endtask

    task automatic push_expected();
        for (int n = 0; n < 16; n++) exp_q.push_back({(n == 15), 16'(yr[n]), 16'(yi[n])});
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 16; k++) begin
            xr[k] = 0;
            xi[k] = 0;
        end
    endtask

    task automatic random_frame();
        for (int k = 0; k < 16; k++) begin
            xr[k] = sx($urandom_range(0, 65535), 16);
            xi[k] = sx($urandom_range(0, 65535), 16);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic drive_sample(input int re, input int im, output bit ok);
        int  guard;
        time t0;
        ok = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        in_re = 16'(re);
        in_im = 16'(im);
        while (!ok && guard < 2000) begin
            t0 = $time;
            #1;
            if (in_ready) begin
                ok = 1'b1;
                last_accept_time = t0;
            end
            @(posedge Clock);
            @(negedge Clock);
            guard++;
        end
    endtask

    task automatic send_frame(input bit gaps, input bit check_lat);
        bit ok;
        int cnt;
        for (int k = 0; k < 16; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_re = 16'($urandom_range(0, 65535));
                repeat ($urandom_range(1, 3)) @(negedge Clock);
            end
            drive_sample(xr[k], xi[k], ok);
            if (!ok) chk($sformatf("accept_timeout_k%0d", k), 0, 1);
        end
        if (check_lat) begin
            in_valid = 1'b0;
            cnt = 1;
            while (!out_valid && cnt < 200) begin
                @(negedge Clock);
                cnt++;
            end
            chk("latency", cnt, 33);
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 1000) begin
            @(negedge Clock);
            guard++;
        end
        chk("drain_complete", exp_q.size(), 0);
        exp_q.delete();
        @(negedge Clock);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
    endtask

    always begin
        @(posedge Clock);
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: checks every presented output, stall stability and stale data.
    logic [33:0] held;
    bit          stall_prev = 1'b0;
    int          out_idx = 0;
    logic [32:0] e;
    always @(negedge Clock) begin
        if (started && !Areset) begin
            chk("ready_valid_overlap", in_ready && out_valid, 0);
            if (stall_prev) chk("hold_stable", {out_valid, out_last, out_re, out_im}, held);
            stall_prev = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stale_out_valid", out_valid, 0);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    chk($sformatf("out_n%0d", out_idx), {out_last, out_re, out_im}, e);
                    out_idx = (out_idx + 1) % 16;
                    if (e[32]) last_pop_time = $time;
                end else begin
                    stall_prev = 1'b1;
                    held = {1'b1, out_last, out_re, out_im};
                end
            end
        end else begin
            stall_prev = 1'b0;
            out_idx = 0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        real dr, di;
        for (int t = 0; t < 8; t++) begin
            tw_re[t] = rnd(32768.0 * $cos(2.0 * PI * t / 16.0));
            tw_im[t] = rnd(32768.0 * $sin(2.0 * PI * t / 16.0));
            if (tw_re[t] > 32767) tw_re[t] = 32767;
            if (tw_im[t] > 32767) tw_im[t] = 32767;
        end

        // Reset behaviour
        repeat (3) @(negedge Clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        Areset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        started = 1'b1;
        @(negedge Clock);

        // DC frame
        clear_frame();
        xr[0] = 16384;
        run_model();
        for (int n = 0; n < 16; n++) chk($sformatf("model_dc_n%0d", n), {16'(yr[n]), 16'(yi[n])}, 32'h0400_0000);
        push_expected();
        send_frame(1'b1, 1'b1);
        wait_drain();

        // Nyquist frame with back-pressure
        clear_frame();
        xr[8] = 16384;
        run_model();
        for (int n = 0; n < 16; n++)
            chk($sformatf("model_nyq_n%0d", n), {16'(yr[n]), 16'(yi[n])}, (n % 2 == 0) ? 32'h0400_0000 : 32'hFC00_0000);
        push_expected();
        bp_en = 1'b1;
        send_frame(1'b0, 1'b1);
        wait_drain();
        bp_en = 1'b0;

        // Bin 1, first without and then with back-pressure
        clear_frame();
        xr[1] = 32767;
        run_model();
        chk("model_bin1_n0", {16'(yr[0]), 16'(yi[0])}, 32'h07FF_0000);
        chk("model_bin1_n8", {16'(yr[8]), 16'(yi[8])}, 32'hF800_0000);
        for (int n = 0; n < 16; n++) begin
            dr = yr[n] - 2047.0 * $cos(2.0 * PI * n / 16.0);
            di = yi[n] - 2047.0 * $sin(2.0 * PI * n / 16.0);
            chk($sformatf("model_bin1_ideal_n%0d", n), (dr <= 2.0 && dr >= -2.0 && di <= 2.0 && di >= -2.0), 1);
        end
        push_expected();
        send_frame(1'b0, 1'b1);
        wait_drain();
        push_expected();
        bp_en = 1'b1;
        send_frame(1'b1, 1'b0);
        in_valid = 1'b0;
        wait_drain();

        // Random frames with input gaps and random back-pressure
        for (int f = 0; f < 3; f++) begin
            random_frame();
            run_model();
            push_expected();
            send_frame(1'b1, 1'b1);
            wait_drain();
        end
        bp_en = 1'b0;

        // Reset at COMPUTE cycle 10, then a DC frame
        random_frame();
        send_frame(1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (9) @(negedge Clock);
        Areset = 1'b1;
        @(negedge Clock);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        Areset = 1'b0;
        @(negedge Clock);
        clear_frame();
        xr[0] = 16384;
        run_model();
        push_expected();
        send_frame(1'b0, 1'b1);
        wait_drain();

        // Back-to-back frames with in_valid held high
        bp_en = 1'b1;
        random_frame();
        run_model();
        push_expected();
        send_frame(1'b0, 1'b0);
        random_frame();
        run_model();
        push_expected();
        begin
            bit ok;
            drive_sample(xr[0], xi[0], ok);
            if (!ok) chk("b2b_accept_timeout", 0, 1);
            chk("b2b_accept_cycle", 64'(last_accept_time - last_pop_time), 10);
            for (int k = 1; k < 16; k++) begin
                drive_sample(xr[k], xi[k], ok);
                if (!ok) chk($sformatf("b2b_timeout_k%0d", k), 0, 1);
            end
        end
        in_valid = 1'b0;
        wait_drain();
        bp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
